// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared widths, FSM states and grant encodings for mem_port_arbiter
package arb_pkg;
  localparam int ARB_ADDR_W = 28;
  localparam int ARB_DATA_W = 128;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} grant_e;
endpackage

// File: rtl/arb_select.sv
// rtl/arb_select.sv - combinational I/D winner pick for mem_port_arbiter
// ARB_ROUND_ROBIN_EN: tie goes to the requester not granted last; otherwise D always wins a tie.
module arb_select
  import arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  grant_e last_grant,
  output logic   gnt_valid,
  output grant_e gnt
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    gnt_valid = i_req | d_req;
    gnt       = d_req ? GNT_D : GNT_I;
    if (i_req && d_req) begin
      gnt = (last_grant == GNT_I) ? GNT_D : GNT_I;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    gnt_valid = i_req | d_req;
    gnt       = d_req ? GNT_D : GNT_I;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one line-wide memory port between I-cache and D-cache refills
// Tie policy selected in arb_select by ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;

  logic   gnt_valid;
  grant_e gnt;
  logic   d_req;

  assign d_req = d_read | d_write;

  arb_select u_select (
    .i_req      (i_read),
    .d_req      (d_req),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          last_grant_d = gnt;
          if (gnt == GNT_D) begin
            // A simultaneous read+write from D is treated as the writeback.
            state_d     = BUSY_D;
            mem_addr_d  = d_addr;
            mem_write_d = d_write;
            mem_read_d  = ~d_write;
            mem_wdata_d = d_write ? d_wdata : '0;
          end else begin
            state_d     = BUSY_I;
            mem_addr_d  = i_addr;
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
            mem_wdata_d = '0;
          end
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          i_rdata_d   = mem_rdata;
          i_ready_d   = 1'b1;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RESP;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          d_rdata_d   = mem_rdata;
          d_ready_d   = 1'b1;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_I;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Tie-order expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  typedef struct {
    bit            i_req;
    bit            d_rd;
    bit            d_wr;
    logic [AW-1:0] i_a;
    logic [AW-1:0] d_a;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            lat;
    bit            exp_d;
    bit            exp_wr;
  } vec_t;

  typedef struct {
    bit            is_d;
    bit            is_write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int compared = 0;
  int mismatched = 0;
  int overlap = 0;
  logic [DW-1:0] last_i_rdata = '0;
  logic [DW-1:0] last_d_rdata = '0;

  always @(negedge clk) begin
    if (mem_read && mem_write) overlap++;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit is_d, input bit is_wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    exp_t e;
    e.is_d = is_d; e.is_write = is_wr; e.addr = a; e.wdata = wd; e.rdata = rd;
    sb.push_back(e);
  endtask

  // Acts as the memory for one transaction and checks the cache-side response.
  task automatic serve(input int lat, input bit chk_lat);
    exp_t e;
    int n;
    bit stable;
    logic [AW-1:0] held;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    n = 0;
    do begin @(negedge clk); n++; end while (!(mem_read || mem_write) && n < 40);
    if (n >= 40) begin
      check("strobe_timeout", 0, 1);
      return;
    end
    if (chk_lat) check("strobe_latency", n, 1);
    check("mem_write", mem_write, e.is_write);
    check("mem_read", mem_read, !e.is_write);
    check("mem_addr", mem_addr, e.addr);
    if (e.is_write) check("mem_wdata", mem_wdata, e.wdata);
    stable = 1'b1;
    held = mem_addr;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      if (mem_addr !== held || !(mem_read || mem_write) || i_ready || d_ready) stable = 1'b0;
    end
    check("busy_hold", stable, 1);
    mem_rdata = e.rdata;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = {4{$urandom}};
    n = 1;
    while (!(i_ready || d_ready) && n < 20) begin @(negedge clk); n++; end
    check("ready_latency", n, 1);
    check("ready_port", {i_ready, d_ready}, e.is_d ? 2'b01 : 2'b10);
    check("rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
    check("strobe_dropped", {mem_read, mem_write}, 2'b00);
    if (e.is_d) begin
      d_read = 1'b0; d_write = 1'b0; last_d_rdata = e.rdata;
    end else begin
      i_read = 1'b0; last_i_rdata = e.rdata;
    end
    @(negedge clk);
    check("ready_one_cycle", {i_ready, d_ready}, 2'b00);
  endtask

  initial begin
    int n;
    bit ok;
    vecs[0] = '{1, 0, 0, 28'h0000010, 28'h0, '0, {16{8'hA5}}, 4, 0, 0};
    vecs[1] = '{0, 0, 1, 28'h0, 28'h0000020, {8{16'h1234}}, '0, 2, 1, 1};
    vecs[2] = '{0, 1, 0, 28'h0, 28'h0000030, '0, {4{32'hDEADBEEF}}, 1, 1, 0};
    vecs[3] = '{0, 1, 1, 28'h0, 28'h0000040, {4{32'hCAFEF00D}}, 128'h77, 3, 1, 1};
    vecs[4] = '{1, 0, 0, 28'hFFFFFFF, 28'h0, '0, {DW{1'b1}}, 0, 0, 0};
    vecs[5] = '{0, 1, 0, 28'h0, 28'h0000000, '0, 128'h1, 5, 1, 0};
    vecs[6] = '{1, 0, 0, 28'h5555555, 28'h0, '0, {4{32'h0BADF00D}}, 1, 0, 0};

    #1;
    check("reset_outputs", {mem_read, mem_write, mem_addr, mem_wdata, i_ready, d_ready},
          '0);
    check("reset_rdata", {i_rdata, d_rdata}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      i_read = vecs[v].i_req; i_addr = vecs[v].i_a;
      d_read = vecs[v].d_rd; d_write = vecs[v].d_wr;
      d_addr = vecs[v].d_a; d_wdata = vecs[v].wdata;
      push_exp(vecs[v].exp_d, vecs[v].exp_wr, vecs[v].exp_d ? vecs[v].d_a : vecs[v].i_a,
               vecs[v].wdata, vecs[v].rdata);
      serve(vecs[v].lat, 1);
    end
    check("i_rdata_held", i_rdata, last_i_rdata);
    check("d_rdata_held", d_rdata, last_d_rdata);

    // I arrives while D owns the port; must follow right after D's RESP+IDLE.
    d_read = 1'b1; d_addr = 28'h0000060;
    push_exp(1, 0, 28'h0000060, '0, {4{32'h600D600D}});
    @(negedge clk);
    i_read = 1'b1; i_addr = 28'h0000070;
    push_exp(0, 0, 28'h0000070, '0, {4{32'h70707070}});
    serve(3, 0);
    serve(2, 1);

    // Three tie rounds; D re-requests after each of its grants.
    i_read = 1'b1; i_addr = 28'h0000100;
    d_read = 1'b1; d_addr = 28'h0000200;
`ifdef ARB_ROUND_ROBIN_EN
    push_exp(1, 0, 28'h0000200, '0, 128'hD1);
    push_exp(0, 0, 28'h0000100, '0, 128'hA1);
    serve(1, 1);
    d_read = 1'b1; d_addr = 28'h0000201;
    push_exp(1, 0, 28'h0000201, '0, 128'hD2);
    serve(1, 1);
    serve(1, 1);
`else
    push_exp(1, 0, 28'h0000200, '0, 128'hD1);
    serve(1, 1);
    d_read = 1'b1; d_addr = 28'h0000201;
    push_exp(1, 0, 28'h0000201, '0, 128'hD2);
    serve(1, 1);
    d_read = 1'b1; d_addr = 28'h0000202;
    push_exp(1, 0, 28'h0000202, '0, 128'hD3);
    serve(1, 1);
    push_exp(0, 0, 28'h0000100, '0, 128'hA1);
    serve(1, 1);
`endif

    // Asynchronous reset in the middle of an I refill.
    i_read = 1'b1; i_addr = 28'h0ABCDEF;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_read && n < 10);
    check("pre_reset_strobe", mem_read, 1);
    #1 rst = 1'b1;
    #1;
    check("reset_async_drop", {mem_read, mem_write, i_ready, d_ready}, 4'b0000);
    i_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_rdata = {4{32'h55555555}};
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (i_ready || d_ready || mem_read || mem_write) ok = 1'b0;
    end
    check("stale_ready_ignored", ok, 1);
    check("reset_rdata_cleared", {i_rdata, d_rdata}, '0);

    i_read = 1'b1; i_addr = 28'h0000321;
    push_exp(0, 0, 28'h0000321, '0, {4{32'h13572468}});
    serve(2, 1);

    check("scoreboard_drained", sb.size(), 0);
    check("no_strobe_overlap", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
